// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter that shares one data-memory read/write port among the per-thread LSUs.
// Latency: a request seen in IDLE gives mem valid next cycle; mem ready gives the LSU ready pulse next cycle.
// Backpressure: ungranted LSUs hold valid and wait; the granted access waits on mem ready (watchdog: ARB_TIMEOUT_EN).
module lsu_mem_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           lsu_read_valid,
    input  logic [NUM_REQ*ADDR_BITS-1:0] lsu_read_address,
    input  logic [NUM_REQ-1:0]           lsu_write_valid,
    input  logic [NUM_REQ*ADDR_BITS-1:0] lsu_write_address,
    input  logic [NUM_REQ*DATA_BITS-1:0] lsu_write_data,
    output logic [NUM_REQ-1:0]           lsu_read_ready,
    output logic [NUM_REQ*DATA_BITS-1:0] lsu_read_data,
    output logic [NUM_REQ-1:0]           lsu_write_ready,
    output logic                         mem_read_valid,
    output logic [ADDR_BITS-1:0]         mem_read_address,
    input  logic                         mem_read_ready,
    input  logic [DATA_BITS-1:0]         mem_read_data,
    output logic                         mem_write_valid,
    output logic [ADDR_BITS-1:0]         mem_write_address,
    output logic [DATA_BITS-1:0]         mem_write_data,
    input  logic                         mem_write_ready,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         timeout_error
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                       r_state;
    logic [IDW-1:0]               r_rr_ptr;
    logic [IDW-1:0]               r_grant;
    logic                         r_busy;
    logic                         r_mem_rd_vld;
    logic                         r_mem_wr_vld;
    logic [ADDR_BITS-1:0]         r_mem_rd_addr;
    logic [ADDR_BITS-1:0]         r_mem_wr_addr;
    logic [DATA_BITS-1:0]         r_mem_wr_dat;
    logic [NUM_REQ-1:0]           r_rd_rdy;
    logic [NUM_REQ-1:0]           r_wr_rdy;
    logic [NUM_REQ*DATA_BITS-1:0] r_rd_dat;

    logic [NUM_REQ-1:0]           w_req;
    logic [IDW-1:0]               w_cand [NUM_REQ];
    logic                         w_found;
    logic [IDW-1:0]               w_sel;
    logic [IDW-1:0]               w_next;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]             r_wd_cnt;
    logic                         r_timeout;
    logic                         w_wd_expired;

    // Last cycle the access may wait: the counter starts at 0 on entry, so this ends it after TIMEOUT_CYCLES cycles.
    assign w_wd_expired  = (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_error = r_timeout;
`else
    assign timeout_error = 1'b0;
`endif

    // A watchdog limit below one cycle has no meaning in either build.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_invalid
    end

    assign w_req = lsu_read_valid | lsu_write_valid;

    // Round-robin scan: candidate k is rr_ptr+k; the descending loop lets the lowest offset win.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_next  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand[k] = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_req[w_cand[k]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[k];
                w_next  = IDW'((int'(w_cand[k]) + 1) % NUM_REQ);
            end
        end
    end

    // Arbiter FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_grant       <= '0;
            r_busy        <= 1'b0;
            r_mem_rd_vld  <= 1'b0;
            r_mem_wr_vld  <= 1'b0;
            r_mem_rd_addr <= '0;
            r_mem_wr_addr <= '0;
            r_mem_wr_dat  <= '0;
            r_rd_rdy      <= '0;
            r_wr_rdy      <= '0;
            r_rd_dat      <= '0;
`ifdef ARB_TIMEOUT_EN
            r_wd_cnt      <= '0;
            r_timeout     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant  <= w_sel;
                        r_rr_ptr <= w_next;
                        r_busy   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        r_wd_cnt <= '0;
`endif
                        // A pending read goes first; a write from the same LSU waits for a later grant.
                        if (lsu_read_valid[w_sel]) begin
                            r_state       <= S_READ;
                            r_mem_rd_vld  <= 1'b1;
                            r_mem_rd_addr <= lsu_read_address[w_sel*ADDR_BITS +: ADDR_BITS];
                        end else begin
                            r_state       <= S_WRITE;
                            r_mem_wr_vld  <= 1'b1;
                            r_mem_wr_addr <= lsu_write_address[w_sel*ADDR_BITS +: ADDR_BITS];
                            r_mem_wr_dat  <= lsu_write_data[w_sel*DATA_BITS +: DATA_BITS];
                        end
                    end
                end
                S_READ: begin
                    if (mem_read_ready) begin
                        r_rd_dat[r_grant*DATA_BITS +: DATA_BITS] <= mem_read_data;
                        r_rd_rdy[r_grant] <= 1'b1;
                        r_mem_rd_vld      <= 1'b0;
                        r_state           <= S_RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (w_wd_expired) begin
                        r_rd_dat[r_grant*DATA_BITS +: DATA_BITS] <= '1;
                        r_rd_rdy[r_grant] <= 1'b1;
                        r_mem_rd_vld      <= 1'b0;
                        r_timeout         <= 1'b1;
                        r_state           <= S_RESP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
`endif
                end
                S_WRITE: begin
                    if (mem_write_ready) begin
                        r_wr_rdy[r_grant] <= 1'b1;
                        r_mem_wr_vld      <= 1'b0;
                        r_state           <= S_RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (w_wd_expired) begin
                        r_wr_rdy[r_grant] <= 1'b1;
                        r_mem_wr_vld      <= 1'b0;
                        r_timeout         <= 1'b1;
                        r_state           <= S_RESP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    r_rd_rdy <= '0;
                    r_wr_rdy <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign lsu_read_ready    = r_rd_rdy;
    assign lsu_read_data     = r_rd_dat;
    assign lsu_write_ready   = r_wr_rdy;
    assign mem_read_valid    = r_mem_rd_vld;
    assign mem_read_address  = r_mem_rd_addr;
    assign mem_write_valid   = r_mem_wr_vld;
    assign mem_write_address = r_mem_wr_addr;
    assign mem_write_data    = r_mem_wr_dat;
    assign busy              = r_busy;
    assign grant_id          = r_grant;

endmodule
